// File: rtl/rowmax_scheduler.sv
// Row-maximum scheduler: streams 64-lane chunks through an external max tree
// and folds each chunk's maximum into a running row maximum.
module rowmax_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CNT_WIDTH-1:0]        cfg_chunks,
    input  logic                        abort,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic [LANES*DATA_WIDTH-1:0] cmp_vec,
    input  logic [DATA_WIDTH-1:0]       cmp_max,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [DATA_WIDTH-1:0]       res_max,
    output logic                        busy
);

    localparam int VW = LANES * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  cfg_q, cfg_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [VW-1:0]         vec_q, vec_d;
    logic                  stv_q, stv_d;
    logic                  accept;

    // Stop accepting once all beats are in; the last one still drains via FLUSH.
    assign in_ready  = (state_q == RUN) && (cnt_q != cfg_q);
    assign accept    = in_valid && in_ready;
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign cmp_vec   = vec_q;
    assign res_max   = res_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        max_d   = max_q;
        res_d   = res_q;
        vec_d   = vec_q;
        stv_d   = 1'b0;

        if (stv_q && (cmp_max > max_q)) begin
            max_d = cmp_max;
        end

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    cfg_d = cfg_chunks;
                    cnt_d = '0;
                    max_d = '0;
                    if (cfg_chunks == '0) begin
                        state_d = DONE;
                        res_d   = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (accept) begin
                        vec_d = in_data;
                        stv_d = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_q == cfg_q) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    res_d   = max_q;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cfg_q   <= '0;
            max_q   <= '0;
            res_q   <= '0;
            vec_q   <= '0;
            stv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            max_q   <= max_d;
            res_q   <= res_d;
            vec_q   <= vec_d;
            stv_q   <= stv_d;
        end
    end

endmodule

// File: tb/tb_rowmax_scheduler.sv
// Bench for rowmax_scheduler: behavioural row model plus directed rows,
// with the comparator tree modelled as a plain max over cmp_vec.
module tb_rowmax_scheduler;

    localparam int DW = 16;
    localparam int L  = 64;
    localparam int CW = 16;
    localparam int VW = DW * L;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          res_ready = 1'b0;
    logic [CW-1:0] cfg_chunks = '0;
    logic [VW-1:0] in_data = '0;
    logic          in_ready, res_valid, busy;
    logic [VW-1:0] cmp_vec;
    logic [DW-1:0] res_max;
    logic [DW-1:0] cmp_max;

    rowmax_scheduler #(.DATA_WIDTH(DW), .LANES(L), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_chunks(cfg_chunks),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .cmp_vec(cmp_vec), .cmp_max(cmp_max),
        .res_valid(res_valid), .res_ready(res_ready), .res_max(res_max),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] vmax(input logic [VW-1:0] v);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < L; i++) begin
            if (v[i*DW +: DW] > m) m = v[i*DW +: DW];
        end
        return m;
    endfunction

    always_comb cmp_max = vmax(cmp_vec);

    function automatic logic [VW-1:0] mk(input logic [DW-1:0] fill,
                                         input logic [DW-1:0] pk,
                                         input int lane);
        logic [VW-1:0] v;
        for (int i = 0; i < L; i++) v[i*DW +: DW] = fill;
        v[lane*DW +: DW] = pk;
        return v;
    endfunction

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Row-level model: a row's result is the max of every element accepted
    // since the start, appearing 3 cycles after the last accepted beat.
    logic [DW-1:0] mdl_max = '0;
    int  mdl_cfg = 0, mdl_acc = 0, first_acc = 0, last_acc = 0;
    int  start_cyc = 0;
    bit  row_live = 1'b0;
    bit  prev_rv = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            row_live = 1'b0;
            prev_rv  = 1'b0;
            mdl_acc  = 0;
        end else begin
            if (start && !abort && !busy) begin
                mdl_max   = '0;
                mdl_cfg   = int'(cfg_chunks);
                mdl_acc   = 0;
                row_live  = 1'b1;
                start_cyc = cyc;
            end
            if (in_ready) begin
                chk("in_ready_window", 64'(row_live && mdl_acc < mdl_cfg), 64'd1);
            end
            if (in_valid && in_ready) begin
                if (vmax(in_data) > mdl_max) mdl_max = vmax(in_data);
                if (mdl_acc == 0) first_acc = cyc;
                mdl_acc++;
                last_acc = cyc;
            end
            if (res_valid) begin
                chk("res_expected", 64'(row_live), 64'd1);
                chk("res_max", 64'(res_max), 64'(mdl_max));
                if (!prev_rv && mdl_cfg > 0)
                    chk("latency", 64'(cyc - last_acc), 64'd3);
                if (!prev_rv && mdl_cfg == 0)
                    chk("zero_latency", 64'(cyc - start_cyc), 64'd1);
                if (res_ready) row_live = 1'b0;
            end
            if (abort && busy && !res_valid) row_live = 1'b0;
            prev_rv = res_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        cfg_chunks = CW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [VW-1:0] d);
        int k;
        in_valid = 1'b1;
        in_data = d;
        k = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 20) begin
                chk("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic take(input int hold, input logic [DW-1:0] exp);
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (res_valid) break;
            k++;
            if (k > 20) begin
                chk("result_timeout", 64'd0, 64'd1);
                break;
            end
        end
        chk("res_literal", 64'(res_max), 64'(exp));
        repeat (hold) @(posedge clk);
        #1 res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        chk("res_dropped", 64'(res_valid), 64'd0);
    endtask

    logic [VW-1:0] d1;

    initial begin
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_max", 64'(res_max), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < L; i++) d1[i*DW +: DW] = DW'(i + 1);
        d1[17*DW +: DW] = 16'hBEEF;
        do_start(1);
        send(d1);
        take(0, 16'hBEEF);

        do_start(4);
        send(mk(16'h0050, 16'h0100, 3));
        send(mk(16'h0001, 16'h7FFF, 60));
        send(mk(16'h0002, 16'h8000, 0));
        send(mk(16'h0000, 16'h0003, 63));
        chk("b2b_accepts", 64'(last_acc - first_acc), 64'd3);
        take(0, 16'h8000);

        do_start(3);
        send(mk(16'h0007, 16'h0010, 5));
        tick();
        tick();
        send(mk(16'h0100, 16'h0FFF, 40));
        tick();
        send(mk(16'h01FF, 16'h0200, 22));
        take(5, 16'h0FFF);

        do_start(0);
        @(negedge clk);
        chk("zero_done", 64'(res_valid), 64'd1);
        chk("zero_ready", 64'(in_ready), 64'd0);
        take(0, 16'h0000);

        do_start(5);
        send(mk(16'h0001, 16'h7777, 2));
        send(mk(16'h0001, 16'h6666, 8));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", 64'(busy), 64'd0);
        repeat (4) tick();
        chk("abort_no_res", 64'(res_valid), 64'd0);
        do_start(1);
        send(mk(16'h0001, 16'h0042, 9));
        take(0, 16'h0042);

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", 64'(busy), 64'd0);
        tick();

        do_start(4);
        send(mk(16'h0003, 16'h0900, 1));
        send(mk(16'h0003, 16'h0A00, 2));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_res_max", 64'(res_max), 64'd0);
        chk("mid_rst_cmp_vec", 64'(|cmp_vec), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        do_start(1);
        send(mk(16'h0005, 16'h0005, 0));
        take(0, 16'h0005);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
